serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Bit-serial sequencer for the 1-bit full-subtractor cell (x, y, bin -> diff, bout).
- Accepts two WIDTH-bit unsigned operands on a start handshake.
- Feeds the external cell one bit per cycle, LSB first, and holds the borrow between bits in a register.
- Assembles the WIDTH-bit difference and reports the final borrow. Lets one 1-bit cell serve arbitrary-width subtraction in the subtractor datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled high while the controller is idle.
- a  input  WIDTH  minuend, captured when start is accepted.
- b  input  WIDTH  subtrahend, captured when start is accepted.
- fs_x  output  1  to cell x: current minuend bit.
- fs_y  output  1  to cell y: current subtrahend bit.
- fs_bin  output  1  to cell bin: current borrow register.
- fs_diff  input  1  from cell diff.
- fs_bout  input  1  from cell bout.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result a-b mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b (unsigned).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE.
  - busy=0, done=0, diff=0, bout=0.
  - Borrow register=0, bit counter=0, operand shift registers=0.
  - fs_x, fs_y and fs_bin are driven from those registers, so all three read 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture a, b into shift regs, borrow<=0, cnt<=0, diff<=0, busy<=1, go to RUN.
  - start=0: stay in IDLE; diff and bout hold their previous values.
- RUN, at each edge:
  - diff <= {fs_diff, diff[WIDTH-1:1]}; borrow <= fs_bout; shift a/b regs right by 1; cnt <= cnt+1.
  - When cnt == WIDTH-1: go to DONE, busy<=0, done<=1, bout<=fs_bout.
  - fs_x/fs_y are the LSBs of the shift regs; fs_bin is the borrow reg. The cell is purely combinational, so its outputs are sampled in the same cycle they are produced.
- DONE:
  - Exactly one cycle; done<=0 at the next edge.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start accepted at edge 0 -> busy high after edges 0..WIDTH-1 -> done high between edge WIDTH and edge WIDTH+1.
  - Throughput: one operation per WIDTH+1 cycles.
- start while in RUN: ignored; operands and progress are unaffected.
- a/b changing after acceptance: no effect (captured copies are used).
- diff/bout:
  - Stable from the done pulse until the next accepted start.
  - diff is cleared to 0 on acceptance; partial values are visible during RUN and are not a contract.
- Reset asserted mid-RUN: immediate return to reset values; the partial result is discarded; no done pulse.
- Width rules:
  - Counter is clog2(WIDTH) bits and never wraps past WIDTH-1 inside RUN.
  - Result is modulo 2^WIDTH; the final borrow goes out only on bout.

Optional Feature:
- Macro SUB_CHAIN_EN.
- Defined:
  - Adds input port bin_in (1 bit), sampled together with a/b on start acceptance.
  - The borrow register initialises to bin_in instead of 0, so diff = a-b-bin_in mod 2^WIDTH and bout reflects the full borrow.
  - Allows chaining multi-word subtractions by feeding the previous bout into bin_in.
- Undefined: no bin_in port; initial borrow is always 0.

Test Plan:
- WIDTH=8, real cell attached, a=0x5A, b=0x3C, start pulsed -> done exactly 8 edges after acceptance, diff=0x1E, bout=0; busy high for exactly 8 cycles.
- a=0x00, b=0x01 -> diff=0xFF, bout=1. a=0xFF, b=0xFF -> diff=0x00, bout=0.
- Start held high continuously with a=0x10, b=0x01 then a=0x03, b=0x05 -> back-to-back results 0x0F/0 then 0xFE/1; second busy begins the edge after the first done; starts during RUN ignored.
- Change a/b and pulse start at cycle 3 of RUN -> result still reflects the originally captured operands; no extra done.
- Assert rst_n low at cycle 4 of RUN -> busy, done, diff, bout, fs_x, fs_y, fs_bin all 0 immediately; no done after release until a new start.
- SUB_CHAIN_EN defined: a=0x10, b=0x10, bin_in=1 -> diff=0xFF, bout=1; bin_in=0 -> diff=0x00, bout=0.

Source files
------------

// File: rtl/serial_sub_ctrl_if.sv
// Start/result handshake and full-subtractor cell pins for serial_sub_ctrl.
// bin_in exists only when SUB_CHAIN_EN is defined.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SUB_CHAIN_EN
    logic             bin_in;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             fs_x;
    logic             fs_y;
    logic             fs_bin;
    logic             fs_diff;
    logic             fs_bout;

    modport slave (
        input  start, a, b,
`ifdef SUB_CHAIN_EN
        input  bin_in,
`endif
        input  fs_diff, fs_bout,
        output busy, done, diff, bout,
        output fs_x, fs_y, fs_bin
    );

    modport master (
        output start, a, b,
`ifdef SUB_CHAIN_EN
        output bin_in,
`endif
        output fs_diff, fs_bout,
        input  busy, done, diff, bout,
        input  fs_x, fs_y, fs_bin
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b sequencer driving an external 1-bit full-subtractor, LSB first.
// Latency: done pulses WIDTH edges after start acceptance; one op per WIDTH+1 cycles.
// Backpressure: start only accepted in IDLE/DONE, ignored while busy. SUB_CHAIN_EN adds bin_in.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_sub_ctrl_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;
    logic             w_bin_init;

`ifdef SUB_CHAIN_EN
    assign w_bin_init = bus.bin_in;
`else
    assign w_bin_init = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= w_bin_init;
                        r_cnt    <= '0;
                        r_diff   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Cell is combinational: its outputs belong to the bit presented this cycle.
                    r_diff   <= {bus.fs_diff, r_diff[WIDTH-1:1]};
                    r_borrow <= bus.fs_bout;
                    r_a      <= {1'b0, r_a[WIDTH-1:1]};
                    r_b      <= {1'b0, r_b[WIDTH-1:1]};
                    if (r_cnt == LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_bout  <= bus.fs_bout;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.fs_x   = r_a[0];
    assign bus.fs_y   = r_b[0];
    assign bus.fs_bin = r_borrow;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.diff   = r_diff;
    assign bus.bout   = r_bout;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl with a behavioural full-subtractor cell attached.
module tb_serial_sub_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.WIDTH(WIDTH)) ifc ();

    assign ifc.fs_diff = ifc.fs_x ^ ifc.fs_y ^ ifc.fs_bin;
    assign ifc.fs_bout = (~ifc.fs_x & ifc.fs_y) | (~ifc.fs_x & ifc.fs_bin) | (ifc.fs_y & ifc.fs_bin);

    serial_sub_ctrl #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the acceptance edge; counts edges until done and busy-high samples.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (ifc.busy) bcnt++;
            if (ifc.done) break;
            step();
            lat++;
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic st);
        ifc.a     = a;
        ifc.b     = b;
        ifc.start = st;
`ifdef SUB_CHAIN_EN
        ifc.bin_in = bin;
`else
        if (bin) $display("note: bin ignored without chaining");
`endif
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] exp_d, input logic exp_b);
        int lat, bcnt;
        drive(a, b, bin, 1'b1);
        step();
        drive(~a, ~b, ~bin, 1'b0);
        wait_done(lat, bcnt);
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_busy"}, bcnt, 8);
        chk({tag, "_diff"}, ifc.diff, exp_d);
        chk({tag, "_bout"}, ifc.bout, exp_b);
        step();
        chk({tag, "_pulse"}, ifc.done, 0);
        chk({tag, "_hold"}, ifc.diff, exp_d);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (ifc.done || ifc.busy) seen++;
        end
        chk(tag, seen, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, ifc.busy, 0);
        chk({tag, "_done"}, ifc.done, 0);
        chk({tag, "_diff"}, ifc.diff, 0);
        chk({tag, "_bout"}, ifc.bout, 0);
        chk({tag, "_fsx"}, ifc.fs_x, 0);
        chk({tag, "_fsy"}, ifc.fs_y, 0);
        chk({tag, "_fsbin"}, ifc.fs_bin, 0);
    endtask

    initial begin
        int lat, bcnt;
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        #12;
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op("v5a3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
        run_op("v0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        run_op("vffff", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
        run_op("v807f", 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0);

        // Back-to-back with start held high; operand change during RUN must be ignored.
        drive(8'h10, 8'h01, 1'b0, 1'b1);
        step();
        drive(8'h03, 8'h05, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        chk("b2b1_lat", lat, 8);
        chk("b2b1_diff", ifc.diff, 8'h0F);
        chk("b2b1_bout", ifc.bout, 0);
        chk("b2b1_busy", ifc.busy, 0);
        step();
        drive(8'hAA, 8'h11, 1'b0, 1'b0);
        chk("b2b2_busy", ifc.busy, 1);
        chk("b2b2_done", ifc.done, 0);
        wait_done(lat, bcnt);
        chk("b2b2_lat", lat, 8);
        chk("b2b2_diff", ifc.diff, 8'hFE);
        chk("b2b2_bout", ifc.bout, 1);
        step();

        // Start pulsed with new operands at cycle 3 of RUN.
        drive(8'hC8, 8'h64, 1'b0, 1'b1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        step();
        step();
        step();
        drive(8'h01, 8'hFF, 1'b0, 1'b1);
        step();
        drive(8'h01, 8'hFF, 1'b0, 1'b0);
        wait_done(lat, bcnt);
        chk("midst_lat", lat, 4);
        chk("midst_diff", ifc.diff, 8'h64);
        chk("midst_bout", ifc.bout, 0);
        quiet("midst_extra", 12);

        // Reset at cycle 4 of RUN.
        drive(8'h5A, 8'h3C, 1'b0, 1'b1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("mrst_pre_busy", ifc.busy, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("mrst");
        @(negedge clk);
        rst_n = 1'b1;
        quiet("mrst_after", 12);

`ifdef SUB_CHAIN_EN
        run_op("ch1", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
        run_op("ch0", 8'h10, 8'h10, 1'b0, 8'h00, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
